// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - three-port burst arbiter for a single-port tile memory
//
// Shares one single-port memory among operand-A reader, operand-B reader and
// result writer. A granted requester owns the memory for a whole burst of
// len+1 beats, the address stepping by BANDWIDTH words per beat.
//
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : round-robin arbitration, search starts after last served (A, B, W)
//   undefined : fixed priority W > A > B, no pointer state
//
// Ports:
//   clock, reset_n                   clock, synchronous active-low reset
//   rda_/rdb_/wr_ req, addr, len     burst requests (len = beats minus one)
//   rda_/rdb_/wr_ gnt, done          one-cycle grant / burst-complete pulses
//   rda_/rdb_ valid, data            read beat return to the owning reader
//   wr_data, wr_ready                write beat data and consume strobe
//   mem_read, mem_write, mem_address memory strobes and word address
//   mem_writedata, mem_readdata      memory data buses

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef BANDWIDTH
`define BANDWIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module mem_port_arbiter #(
  parameter int BURST_W = 8
) (
  input  logic                                 clock,
  input  logic                                 reset_n,
  input  logic                                 rda_req,
  input  logic                                 rdb_req,
  input  logic                                 wr_req,
  input  logic [`ADDR_WIDTH-1:0]               rda_addr,
  input  logic [`ADDR_WIDTH-1:0]               rdb_addr,
  input  logic [`ADDR_WIDTH-1:0]               wr_addr,
  input  logic [BURST_W-1:0]                   rda_len,
  input  logic [BURST_W-1:0]                   rdb_len,
  input  logic [BURST_W-1:0]                   wr_len,
  output logic                                 rda_gnt,
  output logic                                 rdb_gnt,
  output logic                                 wr_gnt,
  output logic                                 rda_valid,
  output logic                                 rdb_valid,
  output logic [`BANDWIDTH*`DATA_WIDTH-1:0]    rda_data,
  output logic [`BANDWIDTH*`DATA_WIDTH-1:0]    rdb_data,
  input  logic [`BANDWIDTH*`DATA_WIDTH-1:0]    wr_data,
  output logic                                 wr_ready,
  output logic                                 rda_done,
  output logic                                 rdb_done,
  output logic                                 wr_done,
  output logic                                 mem_read,
  output logic                                 mem_write,
  output logic [`ADDR_WIDTH-1:0]               mem_address,
  output logic [`BANDWIDTH*`DATA_WIDTH-1:0]    mem_writedata,
  input  logic [`BANDWIDTH*`DATA_WIDTH-1:0]    mem_readdata
);

  localparam int AW = `ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

  // requester ids: 0 = A, 1 = B, 2 = W
  state_t             state;
  logic [1:0]         owner;
  logic [BURST_W-1:0] len;
  logic [BURST_W-1:0] beat;
  logic [2:0]         req;
  logic [1:0]         pick;

  assign req = {wr_req, rdb_req, rda_req};

`ifdef ARB_ROUND_ROBIN_EN
  // ptr names the first requester to be searched, i.e. the one after the last served
  logic [1:0] ptr;
  logic [1:0] c0, c1, c2;

  function automatic logic [1:0] nxt(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  always_comb begin
    c0   = ptr;
    c1   = nxt(c0);
    c2   = nxt(c1);
    pick = c0;
    if (req[c2]) pick = c2;
    if (req[c1]) pick = c1;
    if (req[c0]) pick = c0;
  end
`else
  always_comb begin
    pick = 2'd1;
    if (rda_req) pick = 2'd0;
    if (wr_req)  pick = 2'd2;
  end
`endif

  // Non-owner data is don't-care; gating with valid keeps it quiet outside beats.
  assign rda_data      = rda_valid ? mem_readdata : '0;
  assign rdb_data      = rdb_valid ? mem_readdata : '0;
  assign mem_writedata = wr_data;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state       <= IDLE;
      owner       <= 2'd0;
      len         <= '0;
      beat        <= '0;
      rda_gnt     <= 1'b0;
      rdb_gnt     <= 1'b0;
      wr_gnt      <= 1'b0;
      rda_valid   <= 1'b0;
      rdb_valid   <= 1'b0;
      wr_ready    <= 1'b0;
      rda_done    <= 1'b0;
      rdb_done    <= 1'b0;
      wr_done     <= 1'b0;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr         <= 2'd0;
`endif
    end else begin
      rda_gnt   <= 1'b0;
      rdb_gnt   <= 1'b0;
      wr_gnt    <= 1'b0;
      rda_done  <= 1'b0;
      rdb_done  <= 1'b0;
      wr_done   <= 1'b0;
      // read data returns one cycle after the strobe
      rda_valid <= mem_read && (owner == 2'd0);
      rdb_valid <= mem_read && (owner == 2'd1);
      case (state)
        IDLE: begin
          if (|req) begin
            owner     <= pick;
            beat      <= '0;
            rda_gnt   <= (pick == 2'd0);
            rdb_gnt   <= (pick == 2'd1);
            wr_gnt    <= (pick == 2'd2);
            mem_read  <= (pick != 2'd2);
            mem_write <= (pick == 2'd2);
            wr_ready  <= (pick == 2'd2);
            case (pick)
              2'd0:    begin mem_address <= rda_addr; len <= rda_len; end
              2'd1:    begin mem_address <= rdb_addr; len <= rdb_len; end
              default: begin mem_address <= wr_addr;  len <= wr_len;  end
            endcase
`ifdef ARB_ROUND_ROBIN_EN
            ptr <= nxt(pick);
`endif
            state <= BURST;
          end
        end
        BURST: begin
          if (beat == len) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            wr_ready  <= 1'b0;
            rda_done  <= (owner == 2'd0);
            rdb_done  <= (owner == 2'd1);
            wr_done   <= (owner == 2'd2);
            state     <= DRAIN;
          end else begin
            beat        <= beat + BURST_W'(1);
            mem_address <= mem_address + AW'(`BANDWIDTH);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter

`ifndef ADDR_WIDTH
`define ADDR_WIDTH 12
`endif
`ifndef BANDWIDTH
`define BANDWIDTH 8
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 16
`endif

module tb_mem_port_arbiter;

  localparam int AW = `ADDR_WIDTH;
  localparam int BW = `BANDWIDTH;
  localparam int DW = `BANDWIDTH*`DATA_WIDTH;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          reset_n;
  logic          rda_req, rdb_req, wr_req;
  logic [AW-1:0] rda_addr, rdb_addr, wr_addr;
  logic [7:0]    rda_len, rdb_len, wr_len;
  logic          rda_gnt, rdb_gnt, wr_gnt;
  logic          rda_valid, rdb_valid;
  logic [DW-1:0] rda_data, rdb_data, wr_data, mem_writedata, mem_readdata;
  logic          wr_ready, rda_done, rdb_done, wr_done;
  logic          mem_read, mem_write;
  logic [AW-1:0] mem_address;

  int nvec = 0;
  int nerr = 0;

  mem_port_arbiter #(.BURST_W(8)) dut (
    .clock(clock), .reset_n(reset_n),
    .rda_req(rda_req), .rdb_req(rdb_req), .wr_req(wr_req),
    .rda_addr(rda_addr), .rdb_addr(rdb_addr), .wr_addr(wr_addr),
    .rda_len(rda_len), .rdb_len(rdb_len), .wr_len(wr_len),
    .rda_gnt(rda_gnt), .rdb_gnt(rdb_gnt), .wr_gnt(wr_gnt),
    .rda_valid(rda_valid), .rdb_valid(rdb_valid),
    .rda_data(rda_data), .rdb_data(rdb_data),
    .wr_data(wr_data), .wr_ready(wr_ready),
    .rda_done(rda_done), .rdb_done(rdb_done), .wr_done(wr_done),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_writedata(mem_writedata), .mem_readdata(mem_readdata)
  );

  // memory word n holds value n (mod 2^ADDR_WIDTH)
  function automatic logic [DW-1:0] mk(input logic [AW-1:0] a);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < BW; i++)
      d[i*`DATA_WIDTH +: `DATA_WIDTH] = `DATA_WIDTH'(AW'(a + AW'(i)));
    return d;
  endfunction

  always @(posedge clock) if (mem_read) mem_readdata <= mk(mem_address);

  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      nvec++;
      if (mem_read && mem_write) begin
        nerr++;
        $display("FAIL strobe_overlap: mem_read=%b mem_write=%b required not both 1", mem_read, mem_write);
      end
    end
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic clear_inputs;
    rda_req = 0; rdb_req = 0; wr_req = 0;
    rda_addr = '0; rdb_addr = '0; wr_addr = '0;
    rda_len = '0; rdb_len = '0; wr_len = '0;
    wr_data = '0;
  endtask

  task automatic test_reset;
    logic [10:0] s;
    reset_n = 0;
    clear_inputs();
    tick(); tick();
    s = {rda_gnt, rdb_gnt, wr_gnt, rda_valid, rdb_valid, wr_ready, rda_done, rdb_done, wr_done, mem_read, mem_write};
    nvec++;
    if (s !== 11'b0) begin nerr++; $display("FAIL reset_outputs: got %b required %b", s, 11'b0); end
    nvec++;
    if (mem_address !== '0) begin nerr++; $display("FAIL reset_address: got %h required 0", mem_address); end
    reset_n = 1;
    tick(); tick();
    s = {rda_gnt, rdb_gnt, wr_gnt, rda_valid, rdb_valid, wr_ready, rda_done, rdb_done, wr_done, mem_read, mem_write};
    nvec++;
    if (s !== 11'b0) begin nerr++; $display("FAIL idle_outputs: got %b required %b", s, 11'b0); end
  endtask

  task automatic test_single_a;
    rda_req = 1; rda_addr = '0; rda_len = 8'd1;
    tick();
    nvec++;
    if ({rda_gnt, mem_read, mem_address} !== {1'b1, 1'b1, AW'(0)}) begin
      nerr++; $display("FAIL a_beat0: gnt=%b rd=%b addr=%0d required 1 1 0", rda_gnt, mem_read, mem_address);
    end
    rda_req = 0;
    tick();
    nvec++;
    if ({rda_gnt, mem_read, mem_address} !== {1'b0, 1'b1, AW'(8)}) begin
      nerr++; $display("FAIL a_beat1: gnt=%b rd=%b addr=%0d required 0 1 8", rda_gnt, mem_read, mem_address);
    end
    nvec++;
    if (rda_valid !== 1'b1 || rda_data !== mk(AW'(0)) || rdb_valid !== 1'b0) begin
      nerr++; $display("FAIL a_ret0: valid=%b data=%h rdbv=%b required 1 %h 0", rda_valid, rda_data, rdb_valid, mk(AW'(0)));
    end
    tick();
    nvec++;
    if (rda_valid !== 1'b1 || rda_data !== mk(AW'(8)) || rda_done !== 1'b1 || mem_read !== 1'b0 || rdb_valid !== 1'b0) begin
      nerr++; $display("FAIL a_ret1: valid=%b data=%h done=%b rd=%b rdbv=%b required 1 %h 1 0 0",
                       rda_valid, rda_data, rda_done, mem_read, rdb_valid, mk(AW'(8)));
    end
    tick();
    nvec++;
    if (rda_valid !== 1'b0 || rda_done !== 1'b0) begin
      nerr++; $display("FAIL a_after: valid=%b done=%b required 0 0", rda_valid, rda_done);
    end
    tick(); tick();
  endtask

  task automatic test_write;
    wr_req = 1; wr_addr = AW'(16); wr_len = 8'd2; wr_data = DW'(1);
    for (int k = 0; k < 3; k++) begin
      tick();
      nvec++;
      if (mem_write !== 1'b1 || wr_ready !== 1'b1 || mem_address !== AW'(16 + 8*k) ||
          mem_writedata !== DW'(k + 1) || wr_gnt !== (k == 0) || mem_read !== 1'b0) begin
        nerr++; $display("FAIL w_beat%0d: wr=%b rdy=%b addr=%0d data=%0h gnt=%b required 1 1 %0d %0h %b",
                         k, mem_write, wr_ready, mem_address, mem_writedata, wr_gnt, 16 + 8*k, k + 1, k == 0);
      end
      wr_req  = 0;
      wr_data = DW'(k + 2);
    end
    tick();
    nvec++;
    if (mem_write !== 1'b0 || wr_ready !== 1'b0 || wr_done !== 1'b1 || rda_valid !== 1'b0 || rdb_valid !== 1'b0) begin
      nerr++; $display("FAIL w_done: wr=%b rdy=%b done=%b rv=%b%b required 0 0 1 00",
                       mem_write, wr_ready, wr_done, rda_valid, rdb_valid);
    end
    tick(); tick();
  endtask

  task automatic test_wrap;
    logic [AW-1:0] top;
    top = '1;
    top = top - AW'(7);
    rda_req = 1; rda_addr = top; rda_len = 8'd1;
    tick();
    nvec++;
    if (mem_address !== top) begin nerr++; $display("FAIL wrap_beat0: addr=%0d required %0d", mem_address, top); end
    rda_req = 0;
    rda_addr = AW'(100);
    tick();
    nvec++;
    if (mem_address !== AW'(0) || mem_read !== 1'b1) begin
      nerr++; $display("FAIL wrap_beat1: addr=%0d rd=%b required 0 1", mem_address, mem_read);
    end
    tick();
    nvec++;
    if (rda_data !== mk(AW'(0)) || rda_done !== 1'b1) begin
      nerr++; $display("FAIL wrap_data: data=%h done=%b required %h 1", rda_data, rda_done, mk(AW'(0)));
    end
    tick(); tick();
  endtask

  task automatic test_all_three;
    int ids[3];
    int n;
    reset_n = 0;
    clear_inputs();
    rda_req = 1; rdb_req = 1; wr_req = 1;
    rda_addr = AW'(64); rdb_addr = AW'(128); wr_addr = AW'(256);
    tick();
    reset_n = 1;
    n = 0;
    for (int c = 0; c < 40 && n < 3; c++) begin
      tick();
      if (rda_gnt || rdb_gnt || wr_gnt) begin
        nvec++;
        if (int'(rda_gnt) + int'(rdb_gnt) + int'(wr_gnt) != 1) begin
          nerr++; $display("FAIL three_onehot: gnt=%b%b%b required one-hot", rda_gnt, rdb_gnt, wr_gnt);
        end
        ids[n] = rda_gnt ? 0 : rdb_gnt ? 1 : 2;
        if (rda_gnt) rda_req = 0;
        if (rdb_gnt) rdb_req = 0;
        if (wr_gnt)  wr_req  = 0;
        n++;
      end
    end
    nvec++;
    if (n != 3) begin
      nerr++; $display("FAIL three_count: got %0d grants required 3", n);
    end else begin
`ifdef ARB_ROUND_ROBIN_EN
      if (ids[0] != 0 || ids[1] != 1 || ids[2] != 2) begin
        nerr++; $display("FAIL three_order: got %0d %0d %0d required 0 1 2", ids[0], ids[1], ids[2]);
      end
`else
      if (ids[0] != 2 || ids[1] != 0 || ids[2] != 1) begin
        nerr++; $display("FAIL three_order: got %0d %0d %0d required 2 0 1", ids[0], ids[1], ids[2]);
      end
`endif
    end
    clear_inputs();
    for (int c = 0; c < 6; c++) tick();
  endtask

  task automatic test_mid_reset;
    logic [12:0] s;
    logic seen_done;
    rda_req = 1; rda_addr = '0; rda_len = 8'd7;
    tick();
    rda_req = 0;
    tick(); tick();
    nvec++;
    if (mem_address !== AW'(16) || mem_read !== 1'b1) begin
      nerr++; $display("FAIL mr_beat2: addr=%0d rd=%b required 16 1", mem_address, mem_read);
    end
    reset_n = 0;
    tick();
    s = {rda_gnt, rdb_gnt, wr_gnt, rda_valid, rdb_valid, wr_ready, rda_done, rdb_done, wr_done,
         mem_read, mem_write, |mem_address, |rda_data};
    nvec++;
    if (s !== 13'b0) begin nerr++; $display("FAIL mr_zero: got %b required %b", s, 13'b0); end
    reset_n = 1;
    seen_done = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (rda_done || mem_read) seen_done = 1;
    end
    nvec++;
    if (seen_done !== 1'b0) begin nerr++; $display("FAIL mr_nodone: activity=%b required 0", seen_done); end
    rda_req = 1; rdb_req = 1;
    tick();
    nvec++;
    if (rda_gnt !== 1'b1 || rdb_gnt !== 1'b0) begin
      nerr++; $display("FAIL mr_first: gnt a=%b b=%b required 1 0", rda_gnt, rdb_gnt);
    end
    rda_req = 0;
    for (int c = 0; c < 20 && rdb_gnt !== 1'b1; c++) tick();
    nvec++;
    if (rdb_gnt !== 1'b1) begin nerr++; $display("FAIL mr_bgrant: gnt b=%b required 1", rdb_gnt); end
    rdb_req = 0;
    for (int c = 0; c < 6; c++) tick();
  endtask

  task automatic test_back_to_back;
    int ids[4];
    int tms[4];
    int n;
    rda_req = 1; rdb_req = 1; rda_len = 8'd2; rdb_len = 8'd2;
    n = 0;
    for (int c = 0; c < 80 && n < 4; c++) begin
      tick();
      if (rda_gnt || rdb_gnt) begin
        ids[n] = rda_gnt ? 0 : 1;
        tms[n] = c;
        n++;
      end
    end
    nvec++;
    if (n != 4) begin
      nerr++; $display("FAIL b2b_count: got %0d grants required 4", n);
    end else begin
      for (int i = 0; i < 4; i++) begin
        nvec++;
`ifdef ARB_ROUND_ROBIN_EN
        if (ids[i] != (i % 2)) begin nerr++; $display("FAIL b2b_order%0d: got %0d required %0d", i, ids[i], i % 2); end
`else
        if (ids[i] != 0) begin nerr++; $display("FAIL b2b_order%0d: got %0d required 0", i, ids[i]); end
`endif
        if (i > 0) begin
          nvec++;
          if (tms[i] - tms[i-1] != 5) begin
            nerr++; $display("FAIL b2b_gap%0d: got %0d required 5", i, tms[i] - tms[i-1]);
          end
        end
      end
    end
    clear_inputs();
    for (int c = 0; c < 8; c++) tick();
  endtask

  initial begin
    clear_inputs();
    reset_n = 0;
    mem_readdata = '0;
    test_reset();
    test_single_a();
    test_write();
    test_wrap();
    test_all_three();
    test_mid_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port tile memory (`BANDWIDTH` words of `DATA_WIDTH` bits per access, one-cycle registered read latency) among three requesters: operand-A reader, operand-B reader and result writer. Each requester posts a base address and burst length; the arbiter grants one requester at a time and streams the burst, advancing the address by `BANDWIDTH` per beat. It sits between the matrix-op sequencer's load/store engines and the memory instance.

## Interface
- `BURST_W`, 8, width of burst-length fields; max burst 2^`BURST_W` beats
- Widths `ADDR_WIDTH`, `BANDWIDTH`, `DATA_WIDTH` are global defines
- Clocking: one clock; reset is synchronous and active-low
- `clock` in 1: sole clock, all state on rising edge
- `reset_n` in 1: synchronous active-low reset
- `rda_req`, `rdb_req`, `wr_req` in 1 each: request, held until grant
- `rda_addr`, `rdb_addr`, `wr_addr` in `ADDR_WIDTH` each: burst base word address
- `rda_len`, `rdb_len`, `wr_len` in `BURST_W` each: beats minus one
- `rda_gnt`, `rdb_gnt`, `wr_gnt` out 1 each: one-cycle grant pulse
- `rda_valid`, `rdb_valid` out 1 each: read beat valid
- `rda_data`, `rdb_data` out `BANDWIDTH*DATA_WIDTH` each: read beat data
- `wr_data` in `BANDWIDTH*DATA_WIDTH`: write beat data
- `wr_ready` out 1: current `wr_data` consumed this cycle
- `rda_done`, `rdb_done`, `wr_done` out 1 each: one-cycle burst-complete pulse
- `mem_read`, `mem_write` out 1 each: memory strobes, never both high
- `mem_address` out `ADDR_WIDTH`: memory word address
- `mem_writedata` out `BANDWIDTH*DATA_WIDTH`: equals `wr_data`
- `mem_readdata` in `BANDWIDTH*DATA_WIDTH`: memory output, valid cycle after `mem_read`

## Operation
- States: IDLE, BURST, DRAIN.
- IDLE: with any request high, select a winner by policy (see Configuration), latch its addr/len, pulse its `gnt`, go to BURST. No request: stay.
- BURST: one beat per cycle; read owner asserts `mem_read`, writer asserts `mem_write` and `wr_ready`. `mem_address` = base + beat*`BANDWIDTH`, modulo 2^`ADDR_WIDTH`. After beat `len`, go to DRAIN.
- DRAIN: one cycle; the last read beat returns; owner's `done` pulses; go to IDLE.
- Read return: owner's `valid` is high the cycle after each `mem_read`; its `data` = `mem_readdata`. The non-owner's valid stays 0; its data is don't-care.
- Writer holds `wr_data` stable until `wr_ready`, then presents the next beat on the following cycle.
- Request dropped before grant: withdrawn, no beats issued. Request held high after `done`: treated as a new request in the next IDLE.
- Address/length inputs are sampled only on the grant cycle; later changes are ignored.

## Timing
- Reset (`reset_n`=0 at an edge): state IDLE, all strobes/gnt/valid/ready/done = 0, `mem_address` = 0, round-robin pointer = A. Mid-burst reset aborts the burst with no `done`.
- Request high at IDLE edge T: `gnt` and first strobe at T+1; beat k at T+1+k; read valid at T+2+k; DRAIN and `done` at T+2+len.
- Turnaround: IDLE at T+3+len; next grant no earlier than T+4+len.
- Strobes, address and gnt are registered outputs. `valid` is a one-cycle delay of the owner's read strobe.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: round-robin. Search order starts after the last-served requester, cycling A, B, W.
- Undefined: fixed priority W > A > B. No pointer state; starvation of lower priority is permitted.

## Test plan
- A alone, addr 0, len 1: `mem_read` at T+1/T+2 with addresses 0/8. `rda_valid` at T+2/T+3 with memory words 0-7 then 8-15. `rda_done` at T+3. `rdb_valid` stays 0.
- A, B and W all held high from reset release: round-robin grants A, B, W in that order. Without the macro, grants are W, A, B. No cycle has both `mem_read` and `mem_write` high.
- W, addr 16, len 2, data 0x1, 0x2, 0x3 advanced on `wr_ready`: `mem_write` at addresses 16/24/32 with matching data, then `wr_done`.
- A, addr 2^`ADDR_WIDTH`-8, len 1: second beat `mem_address` is 0.
- `reset_n` low during beat 2 of an A len 7 burst: all outputs 0 at the next edge, no `rda_done`. A B request after reset is granted first only if A is not requesting, since the pointer is A.
- A and B requesting continuously with round-robin: grants alternate A, B, A, B. Each grant is separated by len+3 cycles.
